ps2_host_tx: RTL and testbench

Host-to-device transmitter for the PS/2 port: it sends one command byte, such as 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable), to the keyboard using the standard inhibit/request-to-send sequence. It shares the open-drain ps2_clock/ps2_data pins with the existing PS/2 receiver in the skeleton top level. The processor side uses a valid/ready byte handshake. While a transfer is in flight, the block raises rx_inhibit so the receiver ignores bus activity.

---
 rtl/ps2_host_tx.sv | 214 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device byte transmitter.
//
// Sends one command byte to a PS/2 device using the inhibit / request-to-send
// sequence, then sends the byte LSB first with odd parity and a stop bit.
// Finally it collects the device ACK. The pads are open drain: an *_oe output
// of 1 pulls the line low, and 0 releases it.
//
// Ports:
//   clock         system clock (50 MHz nominal)
//   resetn        asynchronous active-low reset
//   tx_data       byte to send, sampled only when tx_valid & tx_ready
//   tx_valid      send request
//   tx_ready      high only while idle
//   tx_done       one-cycle pulse: byte sent and ACK received
//   tx_error      one-cycle pulse: timeout or missing ACK
//   rx_inhibit    high while a transfer is in flight (tells the receiver to ignore the bus)
//   ps2_clock_in  pad level of the PS/2 clock line
//   ps2_data_in   pad level of the PS/2 data line
//   ps2_clock_oe  1 = pull clock pad low
//   ps2_data_oe   1 = pull data pad low
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe
);

  localparam int TW_MIN = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_MIN > 21) ? TW_MIN : 21;
  localparam int IW     = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int FW     = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_RTS       = 3'd2,
    S_SEND      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t          state_r;
  logic            clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
  logic            clk_filt_r;
  logic [FW-1:0]   filt_cnt_r;
  logic            fe_r;
  logic [7:0]      sh_r;
  logic            par_r;
  logic [3:0]      n_r;
  logic [IW-1:0]   icnt_r;
  logic [TW-1:0]   tcnt_r;
  logic            ack_ok_r;
  logic            timeout_s;

  // The counter has reached TIMEOUT_CYCLES on this edge (tcnt_r counts cycles already spent).
  assign timeout_s = (tcnt_r == TW'(TIMEOUT_CYCLES - 1));

  // Two-flop synchronizers for both pads; idle bus level is high.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clock_in;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= ps2_data_in;
      data_sync_r <= data_meta_r;
    end
  end

  // Clock glitch filter: adopt a new level after FILTER_LEN consecutive differing samples.
  // fe_r is a one-cycle strobe raised when the filtered level drops to 0.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_filt_r <= 1'b1;
      filt_cnt_r <= {FW{1'b0}};
      fe_r       <= 1'b0;
    end else begin
      if (clk_sync_r != clk_filt_r) begin
        if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
          clk_filt_r <= clk_sync_r;
          filt_cnt_r <= {FW{1'b0}};
          fe_r       <= ~clk_sync_r;
        end else begin
          filt_cnt_r <= filt_cnt_r + FW'(1);
          fe_r       <= 1'b0;
        end
      end else begin
        filt_cnt_r <= {FW{1'b0}};
        fe_r       <= 1'b0;
      end
    end
  end

  // Transfer sequencer; all handshake and pad outputs are registered here.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r      <= S_IDLE;
      ps2_clock_oe <= 1'b0;
      ps2_data_oe  <= 1'b0;
      tx_ready     <= 1'b1;
      rx_inhibit   <= 1'b0;
      tx_done      <= 1'b0;
      tx_error     <= 1'b0;
      sh_r         <= 8'h00;
      par_r        <= 1'b0;
      n_r          <= 4'd0;
      icnt_r       <= {IW{1'b0}};
      tcnt_r       <= {TW{1'b0}};
      ack_ok_r     <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (tx_valid && tx_ready) begin
            sh_r         <= tx_data;
            par_r        <= ~^tx_data;
            icnt_r       <= {IW{1'b0}};
            state_r      <= S_INHIBIT;
            ps2_clock_oe <= 1'b1;
            ps2_data_oe  <= 1'b0;
            tx_ready     <= 1'b0;
            rx_inhibit   <= 1'b1;
          end
        end
        S_INHIBIT: begin
          if (icnt_r == IW'(INHIBIT_CYCLES - 1)) begin
            state_r     <= S_RTS;
            ps2_data_oe <= 1'b1;
          end else begin
            icnt_r <= icnt_r + IW'(1);
          end
        end
        S_RTS: begin
          // Releasing the clock while data is held low forms the start bit.
          state_r      <= S_SEND;
          ps2_clock_oe <= 1'b0;
          tcnt_r       <= {TW{1'b0}};
          n_r          <= 4'd0;
        end
        S_SEND: begin
          if (timeout_s) begin
            state_r     <= S_IDLE;
            ps2_data_oe <= 1'b0;
            tx_error    <= 1'b1;
            tx_ready    <= 1'b1;
            rx_inhibit  <= 1'b0;
          end else begin
            tcnt_r <= (&tcnt_r) ? tcnt_r : tcnt_r + TW'(1);
            if (fe_r) begin
              n_r <= n_r + 4'd1;
              // n_r is the count before this edge: 0..7 data, 8 parity, 9 stop.
              if (n_r < 4'd8) begin
                ps2_data_oe <= ~sh_r[n_r[2:0]];
              end else if (n_r == 4'd8) begin
                ps2_data_oe <= ~par_r;
              end else begin
                ps2_data_oe <= 1'b0;
                state_r     <= S_ACK;
              end
            end
          end
        end
        S_ACK: begin
          if (timeout_s) begin
            state_r     <= S_IDLE;
            ps2_data_oe <= 1'b0;
            tx_error    <= 1'b1;
            tx_ready    <= 1'b1;
            rx_inhibit  <= 1'b0;
          end else begin
            tcnt_r <= (&tcnt_r) ? tcnt_r : tcnt_r + TW'(1);
            if (fe_r) begin
              ack_ok_r <= ~data_sync_r;
              state_r  <= S_WAIT_IDLE;
            end
          end
        end
        S_WAIT_IDLE: begin
          if (clk_filt_r && data_sync_r) begin
            tx_done    <= ack_ok_r;
            tx_error   <= ~ack_ok_r;
            tx_ready   <= 1'b1;
            rx_inhibit <= 1'b0;
            state_r    <= S_IDLE;
          end
        end
        default: begin
          state_r      <= S_IDLE;
          ps2_clock_oe <= 1'b0;
          ps2_data_oe  <= 1'b0;
          tx_ready     <= 1'b1;
          rx_inhibit   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int FL   = 2;
  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic       clock;
  logic       resetn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_done, tx_error, rx_inhibit;
  logic       ps2_clock_oe, ps2_data_oe;
  logic       ps2_clock_in, ps2_data_in;
  logic       dev_clk_low, dev_data_low;

  // Open-drain bus: either side may pull a line low.
  assign ps2_clock_in = ~(ps2_clock_oe | dev_clk_low);
  assign ps2_data_in  = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
    .clock(clock), .resetn(resetn), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error), .rx_inhibit(rx_inhibit),
    .ps2_clock_in(ps2_clock_in), .ps2_data_in(ps2_data_in),
    .ps2_clock_oe(ps2_clock_oe), .ps2_data_oe(ps2_data_oe)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int oe_run = 0, last_oe_run = 0, since_rel = 0, err_at = -1;
  logic prev_coe = 1'b0;
  logic [1:0] oe_at_pulse = 2'b11;
  logic ready_at_pulse = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  // Bus observer: pulse counts, clock-hold length, cycles since clock release.
  always @(negedge clock) begin
    if (prev_coe && !ps2_clock_oe) since_rel = 0;
    else since_rel++;
    prev_coe = ps2_clock_oe;
    if (ps2_clock_oe) oe_run++;
    else begin
      if (oe_run != 0) last_oe_run = oe_run;
      oe_run = 0;
    end
    if (tx_done) done_cnt++;
    if (tx_error) begin
      err_cnt++;
      err_at = since_rel;
    end
    if (tx_done && tx_error) both_cnt++;
    if (tx_done || tx_error) begin
      oe_at_pulse    = {ps2_clock_oe, ps2_data_oe};
      ready_at_pulse = tx_ready;
    end
  end

  // Device model: wait for request-to-send, then clock out npulses pulses.
  task automatic device_run(input int npulses, input bit ack, output logic [10:0] frame);
    int t;
    frame = 11'h000;
    t = 0;
    while (!(ps2_clock_in && !ps2_data_in) && t < 100) begin
      @(negedge clock);
      t++;
    end
    check_eq("rts_seen", {31'd0, (ps2_clock_in && !ps2_data_in)}, 32'd1);
    repeat (10) @(negedge clock);
    frame[0] = ps2_data_in;
    for (int k = 1; k <= npulses; k++) begin
      dev_clk_low = 1'b1;
      if (k == 11 && ack) dev_data_low = 1'b1;
      repeat (HALF) @(negedge clock);
      if (k <= 10) frame[k] = ps2_data_in;
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      repeat (HALF) @(negedge clock);
    end
  endtask

  task automatic wait_pulse(input int d0, input int e0, input int budget, input string tag);
    int t;
    t = 0;
    while (done_cnt == d0 && err_cnt == e0 && t < budget) begin
      @(negedge clock);
      t++;
    end
    check_eq({tag, "_pulse_seen"}, {31'd0, (done_cnt != d0 || err_cnt != e0)}, 32'd1);
  endtask

  task automatic accept(input logic [7:0] d, input string tag);
    @(negedge clock);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    tx_data  = ~d;
    check_eq({tag, "_ready_lo"}, {31'd0, tx_ready}, 32'd0);
    check_eq({tag, "_inhibit_hi"}, {31'd0, rx_inhibit}, 32'd1);
    check_eq({tag, "_clk_oe_hi"}, {31'd0, ps2_clock_oe}, 32'd1);
  endtask

  task automatic run_tx(input logic [7:0] d, input bit ack, input string tag, output logic [10:0] frame);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    accept(d, tag);
    device_run(11, ack, frame);
    wait_pulse(d0, e0, 300, tag);
    check_eq({tag, "_frame"}, {21'd0, frame}, {21'd0, exp_frame(d)});
    check_eq({tag, "_inhibit_len"}, last_oe_run, INH + 1);
    check_eq({tag, "_done"}, done_cnt - d0, ack ? 1 : 0);
    check_eq({tag, "_error"}, err_cnt - e0, ack ? 0 : 1);
    check_eq({tag, "_oe_at_pulse"}, {30'd0, oe_at_pulse}, 32'd0);
    check_eq({tag, "_ready_at_pulse"}, {31'd0, ready_at_pulse}, 32'd1);
    repeat (3) @(negedge clock);
  endtask

  initial begin
    logic [10:0] fr;
    int d0, e0;
    logic [7:0] rd;
    bit ra;

    resetn = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;

    // Reset and idle
    repeat (5) @(negedge clock);
    check_eq("rst_clk_oe", {31'd0, ps2_clock_oe}, 32'd0);
    check_eq("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    check_eq("rst_ready", {31'd0, tx_ready}, 32'd1);
    check_eq("rst_inhibit", {31'd0, rx_inhibit}, 32'd0);
    resetn = 1'b1;
    repeat (100) @(negedge clock);
    check_eq("idle_pulses", done_cnt + err_cnt, 32'd0);
    check_eq("idle_oe", {30'd0, ps2_clock_oe, ps2_data_oe}, 32'd0);
    check_eq("idle_ready", {31'd0, tx_ready}, 32'd1);

    // Normal sends and parity corner cases
    run_tx(8'hED, 1'b1, "ed", fr);
    run_tx(8'h00, 1'b1, "p00", fr);
    check_eq("p00_parity", {31'd0, fr[9]}, 32'd1);
    run_tx(8'h01, 1'b1, "p01", fr);
    check_eq("p01_parity", {31'd0, fr[9]}, 32'd0);

    // Device does not acknowledge
    run_tx(8'hF4, 1'b0, "nack", fr);

    // Device never clocks: timeout after TO cycles of released clock
    d0 = done_cnt; e0 = err_cnt;
    accept(8'hA5, "tmo");
    wait_pulse(d0, e0, 3000, "tmo");
    check_eq("tmo_cycles", err_at, TO);
    check_eq("tmo_error", err_cnt - e0, 32'd1);
    check_eq("tmo_done", done_cnt - d0, 32'd0);
    check_eq("tmo_oe", {30'd0, oe_at_pulse}, 32'd0);
    check_eq("tmo_ready", {31'd0, ready_at_pulse}, 32'd1);
    repeat (3) @(negedge clock);

    // Reset in the middle of the byte, after the fourth falling edge
    d0 = done_cnt; e0 = err_cnt;
    accept(8'h00, "rmid");
    device_run(3, 1'b0, fr);
    dev_clk_low = 1'b1;
    repeat (10) @(negedge clock);
    check_eq("rmid_data_oe_pre", {31'd0, ps2_data_oe}, 32'd1);
    #3;
    resetn = 1'b0;
    #1;
    check_eq("rmid_oe_async", {30'd0, ps2_clock_oe, ps2_data_oe}, 32'd0);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (50) @(negedge clock);
    check_eq("rmid_no_pulse", (done_cnt - d0) + (err_cnt - e0), 32'd0);
    check_eq("rmid_ready", {31'd0, tx_ready}, 32'd1);
    check_eq("rmid_inhibit", {31'd0, rx_inhibit}, 32'd0);
    run_tx(8'hFF, 1'b1, "after_rst", fr);

    // Randomized bytes with random ACK/NACK
    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom_range(0, 255));
      ra = ($urandom_range(0, 3) != 0);
      run_tx(rd, ra, "rand", fr);
    end

    check_eq("pulse_exclusive", both_cnt, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
